// File: rtl/maxpool2d_window_core.sv
// 2x2 stride-2 max-pool window datapath.
// Takes a raster-order pixel stream, reduces horizontal pairs to their maximum,
// parks even-row pair maxima in a half-width line buffer and, on odd rows, merges
// them with the new pair maximum to emit one pooled pixel per window.
module maxpool2d_window_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned COL_BITS   = 5,
  parameter int unsigned ROW_BITS   = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Frame_Start,
  input  logic                  In_Valid,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  Out_Valid,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Frame_Done
);

  localparam int unsigned HalfW   = IMG_WIDTH / 2;
  localparam int unsigned IdxBits = (HalfW > 1) ? $clog2(HalfW) : 1;

  localparam logic [COL_BITS-1:0] ColLast = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] RowLast = ROW_BITS'(IMG_HEIGHT - 1);

  // Row FSM encoding
  localparam logic ROW_EVEN = 1'b0;
  localparam logic ROW_ODD  = 1'b1;

  logic [COL_BITS-1:0]   col_q, col_d, col_cur;
  logic [ROW_BITS-1:0]   row_q, row_d, row_cur;
  logic                  state_q, state_d, state_cur;
  logic [DATA_WIDTH-1:0] hold_q, hold_d, hold_cur;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] line_buf [HalfW];
  logic [COL_BITS-1:0]   pair_col;
  logic [IdxBits-1:0]    buf_idx;
  logic [DATA_WIDTH-1:0] buf_rd;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;
  logic                  buf_we;
  logic                  col_last;
  logic                  row_last;

  // Effective position for this cycle: Frame_Start makes the current pixel (0,0)
  always_comb begin
    col_cur   = Frame_Start ? '0 : col_q;
    row_cur   = Frame_Start ? '0 : row_q;
    state_cur = Frame_Start ? ROW_EVEN : state_q;
    hold_cur  = Frame_Start ? '0 : hold_q;
    col_last  = (col_cur == ColLast);
    row_last  = (row_cur == RowLast);
    pair_col  = col_cur >> 1;
    buf_idx   = IdxBits'(pair_col);
  end

  // Signed pair and window reductions
  always_comb begin
    buf_rd   = line_buf[buf_idx];
    pair_max = ($signed(hold_cur) > $signed(In_Data)) ? hold_cur : In_Data;
    win_max  = ($signed(buf_rd) > $signed(pair_max)) ? buf_rd : pair_max;
  end

  // Next-state: position tracking, row FSM, pair hold and output scheduling
  always_comb begin
    col_d        = col_cur;
    row_d        = row_cur;
    state_d      = state_cur;
    hold_d       = hold_cur;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;
    if (In_Valid) begin
      if (!col_cur[0]) begin
        hold_d = In_Data;
      end else if (state_cur == ROW_EVEN) begin
        buf_we = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_data_d   = win_max;
        frame_done_d = row_last && col_last;
      end
      if (col_last) begin
        col_d   = '0;
        state_d = (state_cur == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        row_d   = row_last ? '0 : row_cur + ROW_BITS'(1);
      end else begin
        col_d = col_cur + COL_BITS'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= ROW_EVEN;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer: every entry is written on an even row before its odd-row read
  always_ff @(posedge Clk) begin
    if (buf_we) begin
      line_buf[buf_idx] <= pair_max;
    end
  end

  assign Out_Valid  = out_valid_q;
  assign Out_Data   = out_data_q;
  assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_maxpool2d_window_core.sv
// Self-checking bench for maxpool2d_window_core on a 4x4 frame.
module tb_maxpool2d_window_core;
  localparam int DW = 32;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Frame_Start = 1'b0;
  logic          In_Valid = 1'b0;
  logic [DW-1:0] In_Data = '0;
  logic          Out_Valid;
  logic [DW-1:0] Out_Data;
  logic          Frame_Done;

  maxpool2d_window_core #(
    .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .COL_BITS(2), .ROW_BITS(2)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Frame_Start(Frame_Start), .In_Valid(In_Valid),
    .In_Data(In_Data), .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Frame_Done(Frame_Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    logic [DW-1:0] d;
    logic        done;
  } ev_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int proto_err = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int mr = 0;
  int mc = 0;
  logic signed [DW-1:0] fm [H][W];
  logic [DW-1:0] last_out = '0;
  int fwd_exp[4] = '{6, 8, 14, 16};

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Drive one cycle, advance the frame model, record what the DUT shows after the edge
  task automatic step(input logic v, input logic [DW-1:0] d, input logic fs);
    logic signed [DW-1:0] m;
    @(negedge Clk);
    In_Valid = v; In_Data = d; Frame_Start = fs;
    @(posedge Clk);
    cyc++;
    if (fs) begin mr = 0; mc = 0; end
    if (v) begin
      fm[mr][mc] = d;
      if (mr % 2 == 1 && mc % 2 == 1) begin
        m = smax(smax(fm[mr-1][mc-1], fm[mr-1][mc]), smax(fm[mr][mc-1], fm[mr][mc]));
        exp_q.push_back('{cyc, m, (mr == H-1 && mc == W-1)});
      end
      mc++;
      if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
    end
    #1;
    if (Out_Valid === 1'b1) begin
      obs_q.push_back('{cyc, Out_Data, Frame_Done});
      last_out = Out_Data;
    end else begin
      if (Frame_Done !== 1'b0) proto_err++;
      if (Out_Data !== last_out) proto_err++;
    end
  endtask

  task automatic reset_dut();
    Rst = 1'b1; In_Valid = 1'b0; Frame_Start = 1'b0; In_Data = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    mr = 0; mc = 0; last_out = '0; proto_err = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic compare_model(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].cyc != exp_q[i].cyc ||
          obs_q[i].done !== exp_q[i].done) begin
        errors++;
        $display("FAIL %s_out[%0d]: got data %0d cyc %0d done %b, want data %0d cyc %0d done %b",
                 name, i, $signed(obs_q[i].d), obs_q[i].cyc, obs_q[i].done,
                 $signed(exp_q[i].d), exp_q[i].cyc, exp_q[i].done);
      end
    end
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL %s_protocol: got %0d hold/done violations, want 0", name, proto_err);
    end
  endtask

  task automatic compare_const(input string name, input int first, input int want[4]);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (first + i >= obs_q.size()) begin
        errors++;
        $display("FAIL %s_const[%0d]: got no output, want %0d", name, i, want[i]);
      end else if (obs_q[first+i].d !== DW'(want[i])) begin
        errors++;
        $display("FAIL %s_const[%0d]: got %0d, want %0d", name, i,
                 $signed(obs_q[first+i].d), want[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1 Rst = 1'b1;
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || Out_Data !== '0 || Frame_Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid %b data %0h done %b, want 0 0 0",
               Out_Valid, Out_Data, Frame_Done);
    end
    reset_dut();
    repeat (3) step(1'b0, DW'(7), 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d outputs, want 0", obs_q.size());
    end
  endtask

  task automatic test_basic();
    reset_dut();
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    compare_model("basic");
    compare_const("basic", 0, fwd_exp);
  endtask

  task automatic test_signed();
    int rows[8] = '{-5, -3, -9, -1, -7, -8, -2, -4};
    int want2[4] = '{-3, -1, 0, 0};
    reset_dut();
    for (int i = 0; i < 8; i++) step(1'b1, DW'(rows[i]), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    compare_model("signed");
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i].d !== DW'(want2[i])) begin
        errors++;
        $display("FAIL signed_const[%0d]: got %0d, want %0d", i,
                 (i < obs_q.size()) ? $signed(obs_q[i].d) : 0, want2[i]);
      end
    end
  endtask

  task automatic test_gaps();
    reset_dut();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step(1'b1, DW'(r * W + c + 1), 1'b0);
        step(1'b0, DW'($urandom), 1'b0);
      end
      repeat (5) step(1'b0, DW'($urandom), 1'b0);
    end
    compare_model("gaps");
    compare_const("gaps", 0, fwd_exp);
  endtask

  task automatic test_back_to_back();
    int rev_exp[4] = '{16, 14, 8, 6};
    int dones = 0;
    reset_dut();
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
    for (int i = 16; i >= 1; i--) step(1'b1, DW'(i), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    compare_model("b2b");
    compare_const("b2b_f1", 0, fwd_exp);
    compare_const("b2b_f2", 4, rev_exp);
    foreach (obs_q[i]) if (obs_q[i].done === 1'b1) dones++;
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, want 2", dones);
    end
  endtask

  task automatic test_frame_start();
    int dones = 0;
    reset_dut();
    for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, DW'(1), 1'b1);
    for (int i = 2; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    compare_model("fstart");
    compare_const("fstart", 1, fwd_exp);
    foreach (obs_q[i]) if (obs_q[i].done === 1'b1) dones++;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL fstart_done_count: got %0d, want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 1; i <= 13; i++) step(1'b1, DW'(i), 1'b0);
    checks++;
    if (Out_Data !== DW'(8)) begin
      errors++;
      $display("FAIL rstmid_pre: got %0d, want 8", Out_Data);
    end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || Out_Data !== '0 || Frame_Done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got valid %b data %0d done %b, want 0 0 0",
               Out_Valid, Out_Data, Frame_Done);
    end
    @(negedge Clk);
    In_Valid = 1'b1; In_Data = DW'(14);
    @(posedge Clk);
    #1;
    checks++;
    if (Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_px14: got valid %b, want 0", Out_Valid);
    end
    @(negedge Clk);
    Rst = 1'b0; In_Valid = 1'b0;
    mr = 0; mc = 0; last_out = '0; proto_err = 0;
    exp_q.delete(); obs_q.delete();
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
    repeat (2) step(1'b0, '0, 1'b0);
    compare_model("rstmid");
    compare_const("rstmid", 0, fwd_exp);
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(3) != 0), DW'($urandom), ($urandom_range(60) == 0));
    end
    repeat (2) step(1'b0, '0, 1'b0);
    compare_model("random");
    checks++;
    if (exp_q.size() < 10) begin
      errors++;
      $display("FAIL random_coverage: got %0d windows, want at least 10", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_gaps();
    test_back_to_back();
    test_frame_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
